// File: rtl/sd_dat_rx_pkg.sv
// Shared SD DAT-path definitions: block geometry, CRC16 polynomial, the
// receiver state encoding and a single-bit CRC16 step function reused by
// the RX and TX CRC generators.
package sd_dat_rx_pkg;

  localparam int unsigned SD_BLOCK_NIBBLES = 1024;
  localparam logic [15:0] SD_CRC16_POLY    = 16'h1021;
  localparam int unsigned SD_CRC_BITS      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } rx_state_t;

  // One serial CRC16 step, MSB-first, feedback = incoming bit ^ crc[15].
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic        data_bit);
    logic [15:0] next;
    next = {crc[14:0], 1'b0};
    if (data_bit ^ crc[15]) begin
      next = next ^ SD_CRC16_POLY;
    end
    return next;
  endfunction

endpackage

// File: rtl/sd_dat_rx_crc_16.sv
// sd_crc_16: single-bit serial CRC16 (poly 0x1021, initial value 0).
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   clear    restart the CRC at zero (has priority over enable)
//   enable   shift data_bit into the CRC this cycle
//   data_bit serial input bit
//   crc      current CRC value
module sd_crc_16
  import sd_dat_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_bit,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc16_step(crc, data_bit);
    end
  end

endmodule

// File: rtl/sd_dat_rx.sv
// sd_dat_rx: SD 4-bit DAT-line block receiver.
// Samples DAT[3:0] on each SD clock strobe, waits for the start bit,
// deserialises 512-byte blocks into big-endian 32-bit words for the RX FIFO,
// checks per-line CRC16 and end bits, and enforces a start-bit timeout.
// Ports:
//   i_clk, i_reset          system clock, synchronous active-high reset
//   i_sd_clk_strobe         one-cycle pulse per SD clock rising edge
//   i_sd_dat[3:0]           synchronised DAT lines
//   i_start / i_stop        arm / abort reception
//   i_block_count[7:0]      blocks to receive (0 = 256)
//   o_busy                  reception in progress
//   o_crc_error, o_timeout, o_overrun   sticky status, cleared by i_start
//   o_rx_fifo_push/_data    registered one-cycle FIFO write
//   i_rx_fifo_full          FIFO full; a word completed while full is dropped
module sd_dat_rx
  import sd_dat_rx_pkg::*;
#(
  parameter logic [19:0] TIMEOUT_STROBES = 20'hFFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sd_clk_strobe,
  input  logic [3:0]  i_sd_dat,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [7:0]  i_block_count,
  output logic        o_busy,
  output logic        o_crc_error,
  output logic        o_timeout,
  output logic        o_overrun,
  output logic        o_rx_fifo_push,
  output logic [31:0] o_rx_fifo_data,
  input  logic        i_rx_fifo_full
);

  localparam logic [9:0] LAST_NIBBLE  = 10'(SD_BLOCK_NIBBLES - 1);
  localparam logic [3:0] LAST_CRC_BIT = 4'(SD_CRC_BITS - 1);

  rx_state_t         state;
  logic [9:0]        nibble_cnt;
  logic [3:0]        crc_bit_cnt;
  logic [8:0]        blocks_left;
  logic [19:0]       timeout_cnt;
  logic [31:0]       word_sr;
  logic [3:0][15:0]  rx_crc;
  logic [3:0][15:0]  calc_crc;

  logic [31:0] word_next;
  logic        word_done;
  logic        start_seen;
  logic        data_en;
  logic        crc_ok;

  always_comb begin
    word_next  = {word_sr[27:0], i_sd_dat};
    word_done  = (state == ST_DATA) && i_sd_clk_strobe && (nibble_cnt[2:0] == 3'd7);
    start_seen = (state == ST_WAIT_START) && i_sd_clk_strobe && (i_sd_dat == 4'b0000);
    data_en    = (state == ST_DATA) && i_sd_clk_strobe;
    crc_ok     = (rx_crc == calc_crc);
  end

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc_16 u_crc (
      .clk      (i_clk),
      .reset    (i_reset),
      .clear    (start_seen),
      .enable   (data_en),
      .data_bit (i_sd_dat[i]),
      .crc      (calc_crc[i])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= ST_IDLE;
      nibble_cnt     <= '0;
      crc_bit_cnt    <= '0;
      blocks_left    <= '0;
      timeout_cnt    <= '0;
      word_sr        <= '0;
      rx_crc         <= '0;
      o_busy         <= 1'b0;
      o_crc_error    <= 1'b0;
      o_timeout      <= 1'b0;
      o_overrun      <= 1'b0;
      o_rx_fifo_push <= 1'b0;
      o_rx_fifo_data <= '0;
    end else begin
      // Word output is handled ahead of the FSM so a word completed on the
      // same cycle as i_stop is still pushed (or flagged as overrun).
      o_rx_fifo_push <= 1'b0;
      if (word_done) begin
        if (i_rx_fifo_full) begin
          o_overrun <= 1'b1;
        end else begin
          o_rx_fifo_push <= 1'b1;
          o_rx_fifo_data <= word_next;
        end
      end

      if (i_stop) begin
        state  <= ST_IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              state       <= ST_WAIT_START;
              o_busy      <= 1'b1;
              blocks_left <= {(i_block_count == 8'd0), i_block_count};
              timeout_cnt <= '0;
              o_crc_error <= 1'b0;
              o_timeout   <= 1'b0;
              o_overrun   <= 1'b0;
            end
          end

          ST_WAIT_START: begin
            if (i_sd_clk_strobe) begin
              if (i_sd_dat == 4'b0000) begin
                state      <= ST_DATA;
                nibble_cnt <= '0;
              end else if (timeout_cnt + 20'd1 >= TIMEOUT_STROBES) begin
                o_timeout <= 1'b1;
                o_busy    <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                timeout_cnt <= timeout_cnt + 20'd1;
              end
            end
          end

          ST_DATA: begin
            if (i_sd_clk_strobe) begin
              word_sr    <= word_next;
              nibble_cnt <= nibble_cnt + 10'd1;
              if (nibble_cnt == LAST_NIBBLE) begin
                state       <= ST_CRC;
                crc_bit_cnt <= '0;
              end
            end
          end

          ST_CRC: begin
            if (i_sd_clk_strobe) begin
              for (int unsigned i = 0; i < 4; i++) begin
                rx_crc[i] <= {rx_crc[i][14:0], i_sd_dat[i]};
              end
              crc_bit_cnt <= crc_bit_cnt + 4'd1;
              if (crc_bit_cnt == LAST_CRC_BIT) begin
                state <= ST_END;
              end
            end
          end

          ST_END: begin
            if (i_sd_clk_strobe) begin
              if ((i_sd_dat != 4'hF) || !crc_ok) begin
                o_crc_error <= 1'b1;
                o_busy      <= 1'b0;
                state       <= ST_IDLE;
              end else if (blocks_left == 9'd1) begin
                o_busy <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                blocks_left <= blocks_left - 9'd1;
                timeout_cnt <= '0;
                state       <= ST_WAIT_START;
              end
            end
          end

          default: begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_dat_rx.sv
module tb_sd_dat_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [3:0]  dat = 4'hF;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  block_count = 8'd1;
  logic        full = 1'b0;

  logic        busy, crc_error, timeout, overrun, push;
  logic [31:0] data;
  logic        to_busy, to_crc_error, to_timeout, to_overrun, to_push;
  logic [31:0] to_data;

  always #5 clk = ~clk;

  sd_dat_rx u_dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_sd_clk_strobe (strobe),
    .i_sd_dat        (dat),
    .i_start         (start),
    .i_stop          (stop),
    .i_block_count   (block_count),
    .o_busy          (busy),
    .o_crc_error     (crc_error),
    .o_timeout       (timeout),
    .o_overrun       (overrun),
    .o_rx_fifo_push  (push),
    .o_rx_fifo_data  (data),
    .i_rx_fifo_full  (full)
  );

  sd_dat_rx #(.TIMEOUT_STROBES(20'd16)) u_to (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_sd_clk_strobe (strobe),
    .i_sd_dat        (dat),
    .i_start         (start),
    .i_stop          (stop),
    .i_block_count   (block_count),
    .o_busy          (to_busy),
    .o_crc_error     (to_crc_error),
    .o_timeout       (to_timeout),
    .o_overrun       (to_overrun),
    .o_rx_fifo_push  (to_push),
    .o_rx_fifo_data  (to_data),
    .i_rx_fifo_full  (full)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          timing_err = 0;
  int          to_pushes = 0;
  logic        push_d = 1'b0;

  // Push monitor: sampled 1 time unit after the edge. A push must coincide
  // with the strobe that completed the word and last exactly one cycle.
  always @(posedge clk) begin
    #1;
    if (push) begin
      got_q.push_back(data);
      if (!strobe) timing_err++;
      if (push_d) timing_err++;
    end
    push_d = push;
    if (to_push) to_pushes++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          blocks;
    logic [7:0]  seed;
    int          flip_line;
    int          bad_end_line;
    int          full_lo;
    int          full_hi;
    int          gap;
    int          exp_pushes;
    logic        exp_crc_err;
    logic        exp_overrun;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } row_t;

  row_t rows[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic [15:0] n;
    n = {c[14:0], 1'b0};
    if (b ^ c[15]) n = n ^ 16'h1021;
    return n;
  endfunction

  function automatic logic [3:0] nib_of(input int n, input logic [7:0] seed);
    logic [7:0] b;
    b = 8'(n / 2) + seed;
    return (n % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic strobe_nib(input logic [3:0] d);
    dat = d;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] seed, input int flip_line, input int bad_end_line,
                            input int full_lo, input int full_hi,
                            output logic busy_after, output logic err_after);
    logic [15:0] bcrc[4];
    logic [3:0]  nib;
    logic [31:0] w;
    logic [3:0]  endv;
    w = '0;
    for (int l = 0; l < 4; l++) bcrc[l] = '0;
    strobe_nib(4'h0);
    for (int n = 0; n < 1024; n++) begin
      nib = nib_of(n, seed);
      w = {w[27:0], nib};
      full = (n / 8 >= full_lo) && (n / 8 <= full_hi);
      for (int l = 0; l < 4; l++) bcrc[l] = crc_upd(bcrc[l], nib[l]);
      if ((n % 8 == 7) && !full) exp_q.push_back(w);
      strobe_nib(nib);
    end
    full = 1'b0;
    for (int b = 15; b >= 0; b--) begin
      nib = {bcrc[3][b], bcrc[2][b], bcrc[1][b], bcrc[0][b]};
      if (b == 0 && flip_line >= 0) nib[flip_line] = ~nib[flip_line];
      strobe_nib(nib);
    end
    endv = 4'hF;
    if (bad_end_line >= 0) endv[bad_end_line] = 1'b0;
    dat = endv;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    busy_after = busy;
    err_after = crc_error;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_row(input int r);
    int   nsent;
    int   mm;
    int   n;
    logic end_busy, end_err;
    got_q.delete();
    exp_q.delete();
    block_count = 8'(rows[r].blocks);
    pulse_start();
    nsent = (rows[r].flip_line >= 0 || rows[r].bad_end_line >= 0) ? 1 : rows[r].blocks;
    end_busy = 1'b1;
    end_err = 1'b0;
    for (int b = 0; b < nsent; b++) begin
      if (b > 0) repeat (rows[r].gap) strobe_nib(4'hF);
      send_block(rows[r].seed + 8'(b * 64), rows[r].flip_line, rows[r].bad_end_line,
                 rows[r].full_lo, rows[r].full_hi, end_busy, end_err);
    end
    repeat (4) @(negedge clk);
    check($sformatf("row%0d pushes", r), 32'(got_q.size()), 32'(rows[r].exp_pushes));
    mm = 0;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) mm++;
    check($sformatf("row%0d word mismatches", r), 32'(mm), 32'd0);
    check($sformatf("row%0d first word", r),
          (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF, rows[r].exp_first);
    check($sformatf("row%0d last word", r),
          (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hDEAD_BEEF, rows[r].exp_last);
    check($sformatf("row%0d busy after end", r), {31'd0, end_busy}, 32'd0);
    check($sformatf("row%0d crc_error at end", r), {31'd0, end_err}, {31'd0, rows[r].exp_crc_err});
    check($sformatf("row%0d overrun", r), {31'd0, overrun}, {31'd0, rows[r].exp_overrun});
    check($sformatf("row%0d timeout", r), {31'd0, timeout}, 32'd0);
  endtask

  initial begin
    logic [3:0] nib;

    //           blocks seed  flip bad  flo  fhi gap push err ovr first          last
    rows[0] = '{1, 8'h00, -1, -1, -1, -1,  0, 128, 1'b0, 1'b0, 32'h00010203, 32'hFCFDFEFF};
    rows[1] = '{3, 8'h00, -1, -1, -1, -1, 20, 384, 1'b0, 1'b0, 32'h00010203, 32'h7C7D7E7F};
    rows[2] = '{2, 8'h00,  2, -1, -1, -1, 20, 128, 1'b1, 1'b0, 32'h00010203, 32'hFCFDFEFF};
    rows[3] = '{1, 8'h00, -1,  0, -1, -1,  0, 128, 1'b1, 1'b0, 32'h00010203, 32'hFCFDFEFF};
    rows[4] = '{1, 8'h00, -1, -1, 10, 12,  0, 125, 1'b0, 1'b1, 32'h00010203, 32'hFCFDFEFF};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset push", {31'd0, push}, 32'd0);
    check("reset data", data, 32'd0);
    check("reset crc_error", {31'd0, crc_error}, 32'd0);
    check("reset timeout", {31'd0, timeout}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);

    for (int r = 0; r < 5; r++) run_row(r);

    // Stop while idle keeps sticky flags (overrun left over from last row).
    pulse_stop();
    check("stop idle overrun kept", {31'd0, overrun}, 32'd1);

    // Stop together with start while idle: stop wins.
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start+stop stays idle", {31'd0, busy}, 32'd0);

    // Stop on the strobe that completes word 37: that push still issues.
    got_q.delete();
    block_count = 8'd1;
    pulse_start();
    check("busy after start", {31'd0, busy}, 32'd1);
    check("start clears overrun", {31'd0, overrun}, 32'd0);
    strobe_nib(4'h0);
    for (int n = 0; n < 295; n++) strobe_nib(nib_of(n, 8'h00));
    dat = nib_of(295, 8'h00);
    strobe = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    stop = 1'b0;
    check("stop busy falls", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("stop pushes", 32'(got_q.size()), 32'd37);
    check("stop last word", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 32'hDEAD_BEEF,
          32'h90919293);
    check("stop crc_error", {31'd0, crc_error}, 32'd0);
    check("stop timeout", {31'd0, timeout}, 32'd0);

    // Start-bit timeout on the 16-strobe instance.
    pulse_stop();
    to_pushes = 0;
    pulse_start();
    check("to busy after start", {31'd0, to_busy}, 32'd1);
    repeat (15) strobe_nib(4'hF);
    check("to 15 strobes busy", {31'd0, to_busy}, 32'd1);
    check("to 15 strobes timeout", {31'd0, to_timeout}, 32'd0);
    dat = 4'hF;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("to 16th strobe timeout", {31'd0, to_timeout}, 32'd1);
    check("to 16th strobe busy", {31'd0, to_busy}, 32'd0);
    check("to crc_error", {31'd0, to_crc_error}, 32'd0);
    check("to overrun", {31'd0, to_overrun}, 32'd0);
    check("to pushes", 32'(to_pushes), 32'd0);
    check("main no timeout", {31'd0, timeout}, 32'd0);
    repeat (2) @(negedge clk);
    pulse_start();
    check("to restart clears timeout", {31'd0, to_timeout}, 32'd0);
    check("to restart busy", {31'd0, to_busy}, 32'd1);
    pulse_stop();
    check("to stop busy", {31'd0, to_busy}, 32'd0);

    // Reset in the middle of DATA after an overrun and some pushes.
    pulse_start();
    strobe_nib(4'h0);
    for (int n = 0; n < 100; n++) begin
      full = (n / 8 == 3);
      nib = nib_of(n, 8'h00);
      strobe_nib(nib);
    end
    full = 1'b0;
    check("pre-reset overrun", {31'd0, overrun}, 32'd1);
    check("pre-reset data", data, 32'h2C2D2E2F);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset push", {31'd0, push}, 32'd0);
    check("mid reset data", data, 32'd0);
    check("mid reset overrun", {31'd0, overrun}, 32'd0);
    check("mid reset crc_error", {31'd0, crc_error}, 32'd0);
    check("mid reset timeout", {31'd0, timeout}, 32'd0);
    check("mid reset to_data", to_data, 32'd0);
    check("mid reset to_busy", {31'd0, to_busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("push timing", 32'(timing_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
